// File: rtl/avalon_st_frame_controller_pkg.sv
// Shared types and constants for the Avalon-ST frame controller.
// Frame geometry defaults, FSM encoding and RGB565 field layout.
package avalon_st_frame_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int DEF_XW     = 10;
  localparam int DEF_YW     = 9;

  localparam int RGB565_R_MSB = 15;
  localparam int RGB565_R_LSB = 11;
  localparam int RGB565_G_MSB = 10;
  localparam int RGB565_G_LSB = 5;
  localparam int RGB565_B_MSB = 4;
  localparam int RGB565_B_LSB = 0;

  function automatic logic [15:0] rgb565_pack(
    input logic [4:0] r,
    input logic [5:0] g,
    input logic [4:0] b
  );
    logic [15:0] p;
    p = '0;
    p[RGB565_R_MSB:RGB565_R_LSB] = r;
    p[RGB565_G_MSB:RGB565_G_LSB] = g;
    p[RGB565_B_MSB:RGB565_B_LSB] = b;
    return p;
  endfunction

endpackage

// File: rtl/avalon_st_frame_controller_xy_counter.sv
// Raster position counter for the frame controller.
// Walks x then y; load00 places the counter just past pixel (0,0).
module frame_xy_counter
  import avalon_st_frame_controller_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int XW     = DEF_XW,
  parameter int YW     = DEF_YW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          clr,
  input  logic          load00,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  // Position register: clear, restart after (0,0), or advance one pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (load00) begin
      if (WIDTH == 1) begin
        x <= '0;
        y <= (HEIGHT > 1) ? YW'(1) : '0;
      end else begin
        x <= XW'(1);
        y <= '0;
      end
    end else if (inc) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/avalon_st_frame_controller.sv
// Avalon-ST frame sequencer: sop lock, x/y tracking, length check.
// Reports done/short/long pulses and a good-frame count.
module avalon_st_frame_controller
  import avalon_st_frame_controller_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int XW     = DEF_XW,
  parameter int YW     = DEF_YW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ctrl_enable,
  input  logic          ctrl_contin,
  input  logic          ctrl_abort,
  input  logic          st_valid,
  input  logic          st_sop,
  input  logic          st_eop,
  input  logic          ds_ready,
  output logic          st_ready,
  output logic          px_fire,
  output logic [XW-1:0] px_x,
  output logic [YW-1:0] px_y,
  output logic          px_last,
  output logic          busy,
  output logic          frame_done,
  output logic          err_short,
  output logic          err_long,
  output logic [15:0]   frame_count
);

  localparam bit ONE_PIX = (WIDTH * HEIGHT == 1);

  state_t state;
  state_t state_nx;

  logic beat;
  logic at_origin;
  logic inc;
  logic clr;
  logic load00;
  logic exit_frame;
  logic done_d;
  logic short_d;
  logic long_d;

  frame_xy_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_xy (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (inc),
    .clr     (clr),
    .load00  (load00),
    .x       (px_x),
    .y       (px_y),
    .last    (px_last)
  );

  assign st_ready  = (state == ST_SYNC)
                   | (state == ST_FLUSH)
                   | ((state == ST_ACTIVE) & ds_ready);
  assign beat      = st_valid & st_ready;
  assign at_origin = (px_x == '0) && (px_y == '0);
  assign busy      = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, counter controls and frame verdicts
  always_comb begin
    state_nx   = state;
    px_fire    = 1'b0;
    inc        = 1'b0;
    clr        = 1'b0;
    load00     = 1'b0;
    exit_frame = 1'b0;
    done_d     = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ctrl_enable) state_nx = ST_SYNC;
      end
      ST_SYNC: begin
        if (beat && st_sop) begin
          px_fire = 1'b1;
          if (st_eop) begin
            done_d     = ONE_PIX;
            short_d    = !ONE_PIX;
            exit_frame = 1'b1;
          end else if (ONE_PIX) begin
            long_d   = 1'b1;
            clr      = 1'b1;
            state_nx = ST_FLUSH;
          end else begin
            load00   = 1'b1;
            state_nx = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        if (beat) begin
          px_fire = 1'b1;
          if (st_sop && !at_origin) begin
            short_d = 1'b1;
            load00  = 1'b1;
          end else if (st_eop) begin
            done_d     = px_last;
            short_d    = !px_last;
            exit_frame = 1'b1;
          end else if (px_last) begin
            long_d   = 1'b1;
            clr      = 1'b1;
            state_nx = ST_FLUSH;
          end else begin
            inc = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (beat && st_eop) exit_frame = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (exit_frame) begin
      clr      = 1'b1;
      state_nx = (ctrl_enable && ctrl_contin) ? ST_SYNC : ST_IDLE;
    end
    if (ctrl_abort) begin
      state_nx = ST_IDLE;
      clr      = 1'b1;
      inc      = 1'b0;
      load00   = 1'b0;
      done_d   = 1'b0;
      short_d  = 1'b0;
      long_d   = 1'b0;
    end
  end

  // Registered status pulses and good-frame counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done  <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= done_d;
      err_short  <= short_d;
      err_long   <= long_d;
      if (done_d) frame_count <= frame_count + 16'd1;
    end
  end

endmodule
